// File: rtl/dbg_log_arb.sv
// dbg_log_arb: packet-level round-robin merge of N dbg_guv log streams.
// A grant is held from a packet's first flit until its TLAST flit, so log
// packets never interleave. The output is a registered AXI-Stream stage
// that tags each flit with the index of the stream it came from.
module dbg_log_arb #(
  parameter int N_INPUTS   = 3,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_W      = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_INPUTS*DATA_WIDTH-1:0] in_TDATA,
  input  logic [N_INPUTS-1:0]            in_TVALID,
  output logic [N_INPUTS-1:0]            in_TREADY,
  input  logic [N_INPUTS-1:0]            in_TLAST,
  output logic [DATA_WIDTH-1:0]          out_TDATA,
  output logic                           out_TVALID,
  input  logic                           out_TREADY,
  output logic                           out_TLAST,
  output logic [IDX_W-1:0]               out_TID
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      grant_q, grant_d;
  logic [IDX_W-1:0]      last_grant_q, last_grant_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  last_q, last_d;
  logic [IDX_W-1:0]      tid_q, tid_d;

  logic                  space;
  logic [IDX_W-1:0]      idle_pick;
  logic [IDX_W-1:0]      sel;
  logic                  sel_valid;
  logic                  sel_last;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  accept;

  assign space = !valid_q || out_TREADY;
  assign sel   = (state_q == LOCKED) ? grant_q : idle_pick;

  // Round-robin search: first valid stream after the last completed grant, with wrap.
  always_comb begin
    logic             found;
    int               j;
    logic [IDX_W-1:0] cand;
    idle_pick = last_grant_q;
    found     = 1'b0;
    for (int k = 0; k < N_INPUTS; k++) begin
      j = int'(last_grant_q) + 1 + k;
      if (j >= N_INPUTS) begin
        j = j - N_INPUTS;
      end
      cand = IDX_W'(j);
      for (int i = 0; i < N_INPUTS; i++) begin
        if (!found && (cand == IDX_W'(i)) && in_TVALID[i]) begin
          idle_pick = cand;
          found     = 1'b1;
        end
      end
    end
  end

  // Select the current source's flit and drive the one-hot ready vector.
  always_comb begin
    sel_data  = '0;
    sel_last  = 1'b0;
    sel_valid = 1'b0;
    in_TREADY = '0;
    for (int i = 0; i < N_INPUTS; i++) begin
      if (sel == IDX_W'(i)) begin
        sel_data     = in_TDATA[i*DATA_WIDTH +: DATA_WIDTH];
        sel_last     = in_TLAST[i];
        sel_valid    = in_TVALID[i];
        in_TREADY[i] = space && ((state_q == LOCKED) || in_TVALID[i]);
      end
    end
  end

  assign accept = space && sel_valid;

  // Next-state logic: load the output stage on accept, lock or release the grant on TLAST.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    valid_d      = valid_q;
    data_d       = data_q;
    last_d       = last_q;
    tid_d        = tid_q;
    if (space) begin
      if (accept) begin
        valid_d = 1'b1;
        data_d  = sel_data;
        last_d  = sel_last;
        tid_d   = sel;
        if (sel_last) begin
          state_d      = IDLE;
          last_grant_d = sel;
        end else begin
          state_d = LOCKED;
          grant_d = sel;
        end
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  // State and output registers; reset drops any packet in flight and favours stream 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= IDX_W'(N_INPUTS - 1);
      valid_q      <= 1'b0;
      data_q       <= '0;
      last_q       <= 1'b0;
      tid_q        <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      valid_q      <= valid_d;
      data_q       <= data_d;
      last_q       <= last_d;
      tid_q        <= tid_d;
    end
  end

  assign out_TVALID = valid_q;
  assign out_TDATA  = data_q;
  assign out_TLAST  = last_q;
  assign out_TID    = tid_q;

endmodule

// File: tb/tb_dbg_log_arb.sv
// Scoreboard bench for dbg_log_arb: per-stream flit queues feed the inputs,
// expected flits (hand-ordered) sit in a queue that a negedge monitor drains.
module tb_dbg_log_arb;

  localparam int N     = 3;
  localparam int DW    = 32;
  localparam int IDX_W = 2;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    int            gap;
  } flit_t;

  typedef struct {
    logic [IDX_W-1:0] tid;
    logic [DW-1:0]    data;
    logic             last;
  } exp_t;

  logic              clk;
  logic              rst;
  logic [N*DW-1:0]   in_TDATA;
  logic [N-1:0]      in_TVALID;
  logic [N-1:0]      in_TREADY;
  logic [N-1:0]      in_TLAST;
  logic [DW-1:0]     out_TDATA;
  logic              out_TVALID;
  logic              out_TREADY;
  logic              out_TLAST;
  logic [IDX_W-1:0]  out_TID;

  flit_t sq[N][$];
  exp_t  exp_q[$];
  int    checks;
  int    fails;
  logic  rand_ready;

  dbg_log_arb #(.N_INPUTS(N), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_TDATA   (in_TDATA),
    .in_TVALID  (in_TVALID),
    .in_TREADY  (in_TREADY),
    .in_TLAST   (in_TLAST),
    .out_TDATA  (out_TDATA),
    .out_TVALID (out_TVALID),
    .out_TREADY (out_TREADY),
    .out_TLAST  (out_TLAST),
    .out_TID    (out_TID)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  task automatic applyStimulus(input int s, input logic [DW-1:0] d, input logic l, input int gap);
    flit_t f;
    f.data = d;
    f.last = l;
    f.gap  = gap;
    sq[s].push_back(f);
  endtask

  task automatic expectFlit(input int tid, input logic [DW-1:0] d, input logic l);
    exp_t e;
    e.tid  = IDX_W'(tid);
    e.data = d;
    e.last = l;
    exp_q.push_back(e);
  endtask

  function automatic int pending();
    int n;
    n = exp_q.size();
    for (int i = 0; i < N; i++) n += sq[i].size();
    return n;
  endfunction

  task automatic waitDrain(input int max_cycles);
    int n;
    n = 0;
    while (pending() != 0 && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain_pending", 64'(pending()), 64'd0);
    @(negedge clk);
  endtask

  // Source model: drops fired flits, counts down gaps, presents each stream's head.
  initial begin
    logic [N-1:0] fire;
    flit_t        t;
    in_TVALID  = '0;
    in_TDATA   = '0;
    in_TLAST   = '0;
    forever begin
      @(negedge clk);
      fire = in_TVALID & in_TREADY;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (rst) begin
          sq[i].delete();
        end else if (fire[i]) begin
          void'(sq[i].pop_front());
        end else if (sq[i].size() > 0 && sq[i][0].gap > 0) begin
          t = sq[i][0];
          t.gap = t.gap - 1;
          sq[i][0] = t;
        end
      end
      if (rand_ready) out_TREADY = 1'($urandom_range(0, 1));
      for (int i = 0; i < N; i++) begin
        if (sq[i].size() > 0 && sq[i][0].gap == 0) begin
          in_TVALID[i]         = 1'b1;
          in_TDATA[i*DW +: DW] = sq[i][0].data;
          in_TLAST[i]          = sq[i][0].last;
        end else begin
          in_TVALID[i]         = 1'b0;
          in_TDATA[i*DW +: DW] = '0;
          in_TLAST[i]          = 1'b0;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every output transfer and checks hold-under-stall.
  logic                     hold_prev = 1'b0;
  logic [DW+IDX_W+1:0]      prev_out  = '0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      checkOutput("tready_onehot", 64'($countones(in_TREADY) <= 1), 64'd1);
      if (hold_prev) begin
        checkOutput("stall_hold", 64'({out_TVALID, out_TLAST, out_TID, out_TDATA}), 64'(prev_out));
      end
      if (out_TVALID && out_TREADY) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_flit", 64'({out_TLAST, out_TID, out_TDATA}), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          checkOutput("flit", 64'({out_TLAST, out_TID, out_TDATA}), 64'({e.last, e.tid, e.data}));
        end
      end
      hold_prev = out_TVALID && !out_TREADY;
      prev_out  = {out_TVALID, out_TLAST, out_TID, out_TDATA};
    end else begin
      hold_prev = 1'b0;
    end
  end

  // Directed sequence with hand-ordered expected flits.
  initial begin
    checks     = 0;
    fails      = 0;
    rst        = 1'b1;
    out_TREADY = 1'b1;
    rand_ready = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_valid", 64'(out_TVALID), 64'd0);
    checkOutput("reset_data", 64'(out_TDATA), 64'd0);
    checkOutput("reset_tid", 64'(out_TID), 64'd0);
    checkOutput("reset_last", 64'(out_TLAST), 64'd0);
    #1 rst = 1'b0;

    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checkOutput("idle_valid", 64'(out_TVALID), 64'd0);
      checkOutput("idle_tready", 64'(in_TREADY), 64'd0);
    end

    @(negedge clk);
    for (int n = 0; n < 2; n++) begin
      for (int i = 0; i < N; i++) begin
        applyStimulus(i, 32'hA0 + 32'(i), 1'b1, 0);
        expectFlit(i, 32'hA0 + 32'(i), 1'b1);
      end
    end
    @(negedge clk);
    checkOutput("rot_latency_valid", 64'(out_TVALID), 64'd0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checkOutput("rot_stream_valid", 64'(out_TVALID), 64'd1);
    end
    waitDrain(100);

    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, 32'h10 + 32'(k), (k == 3), 0);
      expectFlit(1, 32'h10 + 32'(k), (k == 3));
    end
    @(negedge clk);
    applyStimulus(0, 32'hB0, 1'b1, 0);
    expectFlit(0, 32'hB0, 1'b1);
    waitDrain(100);

    @(negedge clk);
    applyStimulus(2, 32'h20, 1'b0, 0);
    applyStimulus(2, 32'h21, 1'b0, 0);
    applyStimulus(2, 32'h22, 1'b0, 3);
    applyStimulus(2, 32'h23, 1'b1, 0);
    for (int k = 0; k < 4; k++) expectFlit(2, 32'h20 + 32'(k), (k == 3));
    @(negedge clk);
    applyStimulus(0, 32'hB1, 1'b1, 0);
    expectFlit(0, 32'hB1, 1'b1);
    waitDrain(100);

    @(negedge clk);
    rand_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      for (int i = 0; i < N; i++) applyStimulus(i, 32'hC0 + 32'(i * 16 + n), 1'b1, 0);
      expectFlit(1, 32'hD0 + 32'(n), 1'b1);
      expectFlit(2, 32'hE0 + 32'(n), 1'b1);
      expectFlit(0, 32'hC0 + 32'(n), 1'b1);
    end
    waitDrain(400);
    rand_ready = 1'b0;
    out_TREADY = 1'b1;
    @(negedge clk);

    @(negedge clk);
    for (int k = 0; k < 4; k++) applyStimulus(1, 32'h30 + 32'(k), (k == 3), 0);
    expectFlit(1, 32'h30, 1'b0);
    expectFlit(1, 32'h31, 1'b0);
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_mid_valid", 64'(out_TVALID), 64'd0);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_scoreboard", 64'(exp_q.size()), 64'd0);
    applyStimulus(1, 32'h40, 1'b0, 0);
    applyStimulus(1, 32'h41, 1'b1, 0);
    applyStimulus(0, 32'h50, 1'b0, 0);
    applyStimulus(0, 32'h51, 1'b1, 0);
    expectFlit(0, 32'h50, 1'b0);
    expectFlit(0, 32'h51, 1'b1);
    expectFlit(1, 32'h40, 1'b0);
    expectFlit(1, 32'h41, 1'b1);
    waitDrain(100);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
